// File: rtl/ip_mask_filter_if.sv
// Search and register-port signals of ip_mask_filter, grouped for the lookup FSM
// (master side) and the filter itself (slave side).
interface ip_mask_filter_if #(
  parameter int ADDR_W = 5
) ();
  logic              ip_filter_req;
  logic [31:0]       search_ip;
  logic              ip_filter_done;
  logic              found;
  logic [ADDR_W-1:0] match_index;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  logic              table_rd_req;
  logic              table_rd_ack;
  logic [ADDR_W-1:0] table_rd_addr;
  logic [31:0]       table_rd_ip;
  logic [31:0]       table_rd_mask;
  logic              table_rd_valid;

  logic              table_wr_req;
  logic              table_wr_ack;
  logic [ADDR_W-1:0] table_wr_addr;
  logic [31:0]       table_wr_ip;
  logic [31:0]       table_wr_mask;
  logic              table_wr_valid;

  modport master (
    output ip_filter_req, search_ip,
    input  ip_filter_done, found, match_index, hit_count, miss_count,
    output table_rd_req, table_rd_addr,
    input  table_rd_ack, table_rd_ip, table_rd_mask, table_rd_valid,
    output table_wr_req, table_wr_addr, table_wr_ip, table_wr_mask, table_wr_valid,
    input  table_wr_ack
  );

  modport slave (
    input  ip_filter_req, search_ip,
    output ip_filter_done, found, match_index, hit_count, miss_count,
    input  table_rd_req, table_rd_addr,
    output table_rd_ack, table_rd_ip, table_rd_mask, table_rd_valid,
    input  table_wr_req, table_wr_addr, table_wr_ip, table_wr_mask, table_wr_valid,
    output table_wr_ack
  );
endinterface

// File: rtl/ip_mask_filter.sv
// Masked IP filter: DEPTH address/mask entries scanned lowest-index-first on request,
// with an independent req/ack register port for reading and writing entries.
module ip_mask_filter #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  ip_mask_filter_if.slave bus,
  output logic [1:0]      search_state_o,
  output logic [1:0]      reg_state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRIME = 2'd1, S_SEARCH = 2'd2} s_state_t;
  typedef enum logic [1:0] {R_WAIT = 2'd0, R_READ = 2'd1, R_WRITE = 2'd2} r_state_t;

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH);

  s_state_t          s_state_q;
  logic [ADDR_W:0]   addr_q;
  logic [31:0]       search_ip_q;
  logic              done_q;
  logic              found_q;
  logic [ADDR_W-1:0] match_idx_q;
  logic [31:0]       hit_q;
  logic [31:0]       miss_q;

  r_state_t          r_state_q;
  logic              rd_ack_q;
  logic              wr_ack_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [31:0]       wr_ip_q;
  logic [31:0]       wr_mask_q;
  logic              wr_valid_q;
  logic [DEPTH-1:0]  valid_q;

  logic [63:0]       mem [DEPTH];
  logic [63:0]       ram_a_q;
  logic [63:0]       ram_b_q;
  logic [ADDR_W-1:0] ram_b_addr;
  logic              we_b;
  logic [ADDR_W-1:0] cmp_idx;
  logic              hit;

  // Dual-port read-first RAM {ip, mask}: port A feeds the scan, port B the register side.
  assign we_b       = (r_state_q == R_WRITE);
  assign ram_b_addr = (r_state_q == R_WAIT) ? bus.table_rd_addr : reg_addr_q;

  always_ff @(posedge clk) begin
    ram_a_q <= mem[addr_q[ADDR_W-1:0]];
    if (we_b) mem[ram_b_addr] <= {wr_ip_q, wr_mask_q};
    ram_b_q <= mem[ram_b_addr];
  end

  // The RAM word arriving in SEARCH belongs to the entry one behind the address counter.
  assign cmp_idx = addr_q[ADDR_W-1:0] - ADDR_W'(1);
  assign hit     = valid_q[cmp_idx] &&
                   ((search_ip_q & ram_a_q[31:0]) == (ram_a_q[63:32] & ram_a_q[31:0]));

  always_ff @(posedge clk) begin
    if (reset) begin
      s_state_q   <= S_IDLE;
      addr_q      <= '0;
      search_ip_q <= '0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      match_idx_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (s_state_q)
        S_IDLE: begin
          if (bus.ip_filter_req && !done_q) begin
            search_ip_q <= bus.search_ip;
            addr_q      <= '0;
            found_q     <= 1'b0;
            match_idx_q <= '0;
            s_state_q   <= S_PRIME;
          end
        end
        S_PRIME: begin
          addr_q    <= addr_q + 1'b1;
          s_state_q <= S_SEARCH;
        end
        S_SEARCH: begin
          addr_q <= addr_q + 1'b1;
          if (hit) begin
            found_q     <= 1'b1;
            match_idx_q <= cmp_idx;
            done_q      <= 1'b1;
            if (hit_q != 32'hFFFF_FFFF) hit_q <= hit_q + 1'b1;
            s_state_q   <= S_IDLE;
          end else if (addr_q == LAST_ADDR) begin
            found_q     <= 1'b0;
            match_idx_q <= '0;
            done_q      <= 1'b1;
            if (miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 1'b1;
            s_state_q   <= S_IDLE;
          end
        end
        default: s_state_q <= S_IDLE;
      endcase
    end
  end

  // Register port: req is held by the requester until it sees the one-cycle ack, then
  // dropped the next cycle; a req still high in RWAIT starts a new transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q  <= R_WAIT;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      reg_addr_q <= '0;
      wr_ip_q    <= '0;
      wr_mask_q  <= '0;
      wr_valid_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;
      case (r_state_q)
        R_WAIT: begin
          if (bus.table_wr_req) begin
            reg_addr_q <= bus.table_wr_addr;
            wr_ip_q    <= bus.table_wr_ip;
            wr_mask_q  <= bus.table_wr_mask;
            wr_valid_q <= bus.table_wr_valid;
            wr_ack_q   <= 1'b1;
            r_state_q  <= R_WRITE;
          end else if (bus.table_rd_req) begin
            reg_addr_q <= bus.table_rd_addr;
            rd_ack_q   <= 1'b1;
            r_state_q  <= R_READ;
          end
        end
        R_WRITE: begin
          valid_q[reg_addr_q] <= wr_valid_q;
          r_state_q           <= R_WAIT;
        end
        R_READ:  r_state_q <= R_WAIT;
        default: r_state_q <= R_WAIT;
      endcase
    end
  end

  assign bus.ip_filter_done = done_q;
  assign bus.found          = found_q;
  assign bus.match_index    = match_idx_q;
  assign bus.hit_count      = hit_q;
  assign bus.miss_count     = miss_q;
  assign bus.table_rd_ack   = rd_ack_q;
  assign bus.table_wr_ack   = wr_ack_q;
  assign bus.table_rd_ip    = rd_ack_q ? ram_b_q[63:32] : 32'h0;
  assign bus.table_rd_mask  = rd_ack_q ? ram_b_q[31:0]  : 32'h0;
  assign bus.table_rd_valid = rd_ack_q & valid_q[reg_addr_q];
  assign search_state_o     = s_state_q;
  assign reg_state_o        = r_state_q;

endmodule

// File: tb/tb_ip_mask_filter.sv
// Directed bench for ip_mask_filter: table of write+search vectors plus hand-written
// sequences for handshake priority, mid-search writes, saturation and reset abort.
module tb_ip_mask_filter;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic       clk;
  logic       reset;
  logic [1:0] search_state;
  logic [1:0] reg_state;

  ip_mask_filter_if #(.ADDR_W(ADDR_W)) bus ();

  ip_mask_filter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .search_state_o (search_state),
    .reg_state_o    (reg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_ip;
    logic [31:0]       wr_mask;
    logic              wr_valid;
    logic [31:0]       ip;
    logic              exp_found;
    logic [ADDR_W-1:0] exp_idx;
    int                exp_lat;
  } vec_t;

  vec_t        vecs[$];
  logic [64:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_hits = 0;
  logic [31:0] exp_misses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge following done.
  task automatic do_search(input logic [31:0] ip, input logic exp_found,
                           input logic [ADDR_W-1:0] exp_idx, input int exp_lat,
                           input string tag);
    int lat;
    bit seen;
    bus.search_ip     = ip;
    bus.ip_filter_req = 1'b1;
    @(posedge clk);
    #1 bus.ip_filter_req = 1'b0;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.ip_filter_done) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
    check($sformatf("%s_done_seen", tag), 32'(seen), 32'd1);
    if (exp_found) begin
      if (exp_hits != 32'hFFFF_FFFF) exp_hits++;
    end else begin
      if (exp_misses != 32'hFFFF_FFFF) exp_misses++;
    end
    if (seen) begin
      check($sformatf("%s_latency", tag), lat, exp_lat);
      check($sformatf("%s_found", tag), 32'(bus.found), 32'(exp_found));
      check($sformatf("%s_index", tag), 32'(bus.match_index), 32'(exp_idx));
      check($sformatf("%s_hits", tag), bus.hit_count, exp_hits);
      check($sformatf("%s_misses", tag), bus.miss_count, exp_misses);
    end
    @(posedge clk);
    #1 check($sformatf("%s_done_width", tag), 32'(bus.ip_filter_done), 32'd0);
  endtask

  task automatic reg_write(input logic [ADDR_W-1:0] addr, input logic [31:0] ip,
                           input logic [31:0] mask, input logic valid);
    int n;
    bit seen;
    bus.table_wr_addr  = addr;
    bus.table_wr_ip    = ip;
    bus.table_wr_mask  = mask;
    bus.table_wr_valid = valid;
    bus.table_wr_req   = 1'b1;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.table_wr_ack) begin
        seen = 1'b1;
        break;
      end
      n++;
    end
    check("wr_ack_seen", 32'(seen), 32'd1);
    check("wr_ack_latency", n, 1);
    @(posedge clk);
    #1 bus.table_wr_req = 1'b0;
  endtask

  task automatic reg_read(input logic [ADDR_W-1:0] addr, input string tag);
    int n;
    bit seen;
    logic [64:0] exp;
    exp = exp_q.pop_front();
    bus.table_rd_addr = addr;
    bus.table_rd_req  = 1'b1;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.table_rd_ack) begin
        seen = 1'b1;
        break;
      end
      n++;
    end
    check($sformatf("%s_ack_seen", tag), 32'(seen), 32'd1);
    check($sformatf("%s_latency", tag), n, 1);
    check($sformatf("%s_valid", tag), 32'(bus.table_rd_valid), 32'(exp[64]));
    check($sformatf("%s_ip", tag), bus.table_rd_ip, exp[63:32]);
    check($sformatf("%s_mask", tag), bus.table_rd_mask, exp[31:0]);
    @(posedge clk);
    #1 bus.table_rd_req = 1'b0;
  endtask

  initial begin
    int  n;
    bit  done_seen;

    bus.ip_filter_req  = 1'b0;
    bus.search_ip      = '0;
    bus.table_rd_req   = 1'b0;
    bus.table_rd_addr  = '0;
    bus.table_wr_req   = 1'b0;
    bus.table_wr_addr  = '0;
    bus.table_wr_ip    = '0;
    bus.table_wr_mask  = '0;
    bus.table_wr_valid = 1'b0;
    do_reset();

    @(negedge clk);
    check("rst_done", 32'(bus.ip_filter_done), 0);
    check("rst_found", 32'(bus.found), 0);
    check("rst_index", 32'(bus.match_index), 0);
    check("rst_hits", bus.hit_count, 0);
    check("rst_misses", bus.miss_count, 0);
    check("rst_rd_ack", 32'(bus.table_rd_ack), 0);
    check("rst_wr_ack", 32'(bus.table_wr_ack), 0);
    check("rst_rd_ip", bus.table_rd_ip, 0);
    check("rst_rd_mask", bus.table_rd_mask, 0);
    check("rst_rd_valid", 32'(bus.table_rd_valid), 0);
    check("rst_search_state", 32'(search_state), 0);
    check("rst_reg_state", 32'(reg_state), 0);
    @(posedge clk);
    #1;

    // {wr_en, wr_addr, wr_ip, wr_mask, wr_valid, search_ip, found, index, latency}
    vecs.push_back('{1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 32'h0A000001, 1'b0, 5'd0, 34});
    vecs.push_back('{1'b1, 5'd5, 32'h0A010000,  32'hFFFF0000,  1'b1, 32'h0A010203, 1'b1, 5'd5, 8});
    vecs.push_back('{1'b1, 5'd3, 32'h0A000000,  32'hFF000000,  1'b1, 32'h0A010203, 1'b1, 5'd3, 6});
    vecs.push_back('{1'b1, 5'd7, 32'h0A010203,  32'hFFFFFFFF,  1'b1, 32'h0A010203, 1'b1, 5'd3, 6});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 32'h0B010203, 1'b0, 5'd0, 34});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 32'h0A7F0000, 1'b1, 5'd3, 6});
    vecs.push_back('{1'b1, 5'd3, 32'h0A000000,  32'hFF000000,  1'b0, 32'h0A010203, 1'b1, 5'd5, 8});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 32'h0A01FFFF, 1'b1, 5'd5, 8});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 32'h0A020203, 1'b0, 5'd0, 34});
    vecs.push_back('{1'b1, 5'd5, 32'h0A010000,  32'hFFFF0000,  1'b0, 32'h0A010203, 1'b1, 5'd7, 10});
    vecs.push_back('{1'b1, 5'd0, 32'h12345678,  32'h00000000,  1'b0, 32'hDEADBEEF, 1'b0, 5'd0, 34});
    vecs.push_back('{1'b1, 5'd0, 32'h12345678,  32'h00000000,  1'b1, 32'hDEADBEEF, 1'b1, 5'd0, 3});
    vecs.push_back('{1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 32'h0A010203, 1'b1, 5'd0, 3});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr_en)
        reg_write(vecs[i].wr_addr, vecs[i].wr_ip, vecs[i].wr_mask, vecs[i].wr_valid);
      do_search(vecs[i].ip, vecs[i].exp_found, vecs[i].exp_idx, vecs[i].exp_lat,
                $sformatf("vec%0d", i));
    end

    exp_q.push_back({1'b0, 32'h0A010000, 32'hFFFF0000});
    reg_read(5'd5, "rd_entry5");

    // Simultaneous write and read of entry 2: write first, read sees the new contents.
    exp_q.push_back({1'b1, 32'hC0A80001, 32'hFFFFFF00});
    bus.table_wr_addr  = 5'd2;
    bus.table_wr_ip    = 32'hC0A80001;
    bus.table_wr_mask  = 32'hFFFFFF00;
    bus.table_wr_valid = 1'b1;
    bus.table_rd_addr  = 5'd2;
    bus.table_wr_req   = 1'b1;
    bus.table_rd_req   = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.table_wr_ack) break;
      n++;
    end
    check("simul_wr_latency", n, 1);
    check("simul_rd_not_acked", 32'(bus.table_rd_ack), 0);
    @(posedge clk);
    #1 bus.table_wr_req = 1'b0;
    reg_read(5'd2, "simul_rd");

    // Write to an already-scanned entry during a search leaves the result alone.
    reg_write(5'd0, 32'h12345678, 32'h0, 1'b0);
    fork
      do_search(32'h0A010203, 1'b1, 5'd7, 10, "mid_wr");
      begin
        repeat (4) @(posedge clk);
        #1 reg_write(5'd1, 32'h0, 32'h0, 1'b1);
      end
    join
    do_search(32'h0A010203, 1'b1, 5'd1, 4, "after_mid_wr");
    reg_write(5'd1, 32'h0, 32'h0, 1'b0);

    force dut.miss_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #1 release dut.miss_q;
    exp_misses = 32'hFFFF_FFFE;
    do_search(32'h01020304, 1'b0, 5'd0, 34, "sat1");
    do_search(32'h01020304, 1'b0, 5'd0, 34, "sat2");
    do_search(32'h0A010203, 1'b1, 5'd7, 10, "pre_abort");

    // Reset in the middle of a scan: no done pulse, state back to reset values.
    bus.search_ip     = 32'h01020304;
    bus.ip_filter_req = 1'b1;
    @(posedge clk);
    #1 bus.ip_filter_req = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.ip_filter_done) done_seen = 1'b1;
      if (i == 4) check("abort_in_search", 32'(search_state), 2);
      if (i == 5) reset = 1'b1;
      if (i == 7) reset = 1'b0;
    end
    check("abort_no_done", 32'(done_seen), 0);
    check("abort_found", 32'(bus.found), 0);
    check("abort_hits", bus.hit_count, 0);
    check("abort_misses", bus.miss_count, 0);
    check("abort_search_state", 32'(search_state), 0);
    exp_hits   = 0;
    exp_misses = 0;
    @(posedge clk);
    #1;

    exp_q.push_back({1'b0, 32'h0A010203, 32'hFFFFFFFF});
    reg_read(5'd7, "post_rst_rd7");
    do_search(32'h0A010203, 1'b0, 5'd0, 34, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ip_mask_filter.md
# ip_mask_filter

Parametrised successor to the exact-match IP filter in the output-port-lookup path. It holds DEPTH entries, each with a 32-bit address, a 32-bit mask and a valid bit. On request from the lookup state machine it scans the entries in order and reports the lowest-index masked match and its index. A register-side req/ack port reads and writes entries at any time, independent of searches.

## Interface
- DEPTH, 32: number of entries; a power of two, 4..256.
- ADDR_W, log2(DEPTH): entry index width.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ip_filter_req  in  1  search request; sampled only in IDLE.
- search_ip  in  32  address to search; captured on the accepted request.
- ip_filter_done  out  1  one-cycle pulse: search complete.
- found  out  1  result of the last search; held until the next accepted request.
- match_index  out  ADDR_W  index of the matching entry; 0 on a miss; held like found.
- hit_count, miss_count  out  32 each  saturating search statistics.
- table_rd_req / table_rd_ack  in / out  1 each  register read handshake.
- table_rd_addr  in  ADDR_W  entry to read.
- table_rd_ip, table_rd_mask  out  32 each  entry contents; valid only in the ack cycle.
- table_rd_valid  out  1  entry valid bit; valid only in the ack cycle.
- table_wr_req / table_wr_ack  in / out  1 each  register write handshake.
- table_wr_addr  in  ADDR_W  entry to write.
- table_wr_ip, table_wr_mask, table_wr_valid  in  32, 32, 1  new entry contents.

## Operation
- Storage:
  - ip and mask live in a dual-port synchronous RAM with 1-cycle read latency.
  - Port A is read-only and belongs to the search engine; port B belongs to the register port.
  - Valid bits are a DEPTH-bit flop vector; reset clears all of them. RAM contents are not reset.
- Match rule: entry k matches when valid[k] is set and (search_ip & mask[k]) == (ip[k] & mask[k]).
  - A valid entry with mask 0 matches everything.
  - The lowest index wins, because the scan runs 0 → DEPTH-1 and stops at the first hit.
- Search FSM states and transitions:
  - IDLE: on req, latch search_ip, set addr to 0, clear found and match_index, go to PRIME.
  - PRIME: RAM address 0 is presented; go to SEARCH.
  - SEARCH: compare the data for entry k and present address k+1.
    - On a hit, register found=1 and match_index=k, pulse done, increment hit_count, go to IDLE.
    - On a miss at k=DEPTH-1, register found=0 and match_index=0, pulse done, increment miss_count, go to IDLE.
  - The address counter is ADDR_W+1 bits wide so the last entry is detected with no wrap-around ambiguity.
- ip_filter_req outside IDLE is ignored; it is neither queued nor errored.
- Register FSM states: RWAIT, RREAD, RWRITE.
  - In RWAIT a write request has priority over a read request.
  - RWRITE: port B write enable is asserted for one cycle, the valid bit is updated, wr_ack pulses, go to RWAIT.
  - RREAD: rd_ack pulses with RAM data and valid[addr] on the outputs, go to RWAIT.
- Search/write interaction:
  - The RAM is read-first: a write in the same cycle as a search read of that entry returns the old data.
  - A write to an entry the scan has already passed does not affect the current result.
  - A valid-bit write takes effect on the next edge.
- Counters saturate at 32'hFFFFFFFF and clear only on reset.

## Timing
- Reset values:
  - Outputs: done=0, found=0, match_index=0, hit_count=0, miss_count=0, rd_ack=0, wr_ack=0.
  - rd data outputs are 0 during reset.
  - Internal: search FSM in IDLE, register FSM in RWAIT, all valid bits 0.
- Search latency, with the request accepted in cycle T:
  - A hit at entry k gives done in cycle T+3+k.
  - A full miss gives done in cycle T+2+DEPTH.
  - The earliest next request is accepted in the cycle after done.
- Register handshake:
  - Requester holds req until it sees ack, then deasserts it in the following cycle.
  - Read: req seen in cycle c gives ack plus data in cycle c+1.
  - Write: req seen in cycle c writes in cycle c+1 with ack in c+1.
  - Req still high in the cycle after ack starts a new transaction.
- Reset asserted mid-search aborts the search: no done pulse, outputs return to reset values.
- Reset asserted mid-register-access drops the access with no ack; RAM contents are undefined only for a write cut off in its write cycle.

## Test plan
- After reset, search 10.0.0.1 → done at T+2+DEPTH (T+34 for DEPTH=32), found=0, miss_count=1.
- Write entry 5 = 10.1.0.0/FFFF0000 valid; search 10.1.2.3 → done at T+8, found=1, match_index=5, hit_count=1.
- Entries 3 (10.0.0.0/FF000000) and 7 (10.1.2.3/FFFFFFFF), both valid; search 10.1.2.3 → match_index=3.
- Entry 0 has mask 0 but is invalid; search any address → miss. Set it valid; search again → hit at index 0, done at T+3.
- Assert rd_req and wr_req to entry 2 together → write acked first, then read returns the new ip/mask/valid. A wr_req issued mid-search to an entry already passed → no change to the result.
- Preload miss_count near saturation via repeated misses (forced), then add two more misses → the count holds at FFFFFFFF. Reset during SEARCH → no done pulse, found=0.
